// File: rtl/sc_input_cond_if.sv
// Pin-side and hub-side signals of the input conditioner, grouped for port binding.
interface sc_input_cond_if;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [3:0] key_clr;
  logic [3:0] key_level;
  logic [9:0] sw_level;
  logic [3:0] key_press;
  logic       key_any;

  modport master (
    output KEY, SW, key_clr,
    input  key_level, sw_level, key_press, key_any
  );

  modport slave (
    input  KEY, SW, key_clr,
    output key_level, sw_level, key_press, key_any
  );
endinterface

// File: rtl/sc_input_cond.sv
// Synchronizes and debounces 4 keys + 10 switches; sticky W1C press flags per key.
// Latency DEBOUNCE_CYCLES+2 edges from pin to level/press; no backpressure, always accepts.
module sc_input_cond #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input logic            clock,
  input logic            resetn,
  sc_input_cond_if.slave pins
);

  localparam int NCH = 14;
  // Bits [3:0] are keys (idle high), bits [13:4] are switches (idle low).
  localparam logic [NCH-1:0] RST_VAL = 14'h000F;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1_q, s2_q;
  logic [NCH-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [3:0]       press_q, press_d;

  assign raw = {pins.SW, pins.KEY};

  always_comb begin
    stable_d = stable_q;
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c] = '0;
      if (s2_q[c] != stable_q[c]) begin
        if (cnt_q[c] == CNT_MAX) begin
          stable_d[c] = s2_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
    // A new press beats a same-edge clear so no press is lost.
    press_d = (stable_q[3:0] & ~stable_d[3:0]) | (press_q & ~pins.key_clr);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_q     <= RST_VAL;
      s2_q     <= RST_VAL;
      stable_q <= RST_VAL;
      press_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign pins.key_level = ~stable_q[3:0];
  assign pins.sw_level  = stable_q[NCH-1:4];
  assign pins.key_press = press_q;
  assign pins.key_any   = |press_q;

endmodule

// File: tb/tb_sc_input_cond.sv
// Directed bench with a sliding-window debounce model checked every cycle.
module tb_sc_input_cond;
  localparam int DEB = 4;
  localparam logic [13:0] RST = 14'h000F;

  logic clock;
  logic resetn;
  int   checks = 0;
  int   passes = 0;

  sc_input_cond_if tb_if ();

  sc_input_cond #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .clock  (clock),
    .resetn (resetn),
    .pins   (tb_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a channel accepts a new value once the synchronized input (pin two
  // edges ago) has disagreed with the accepted value for DEB edges in a row.
  logic [13:0] hist [0:DEB];
  logic [13:0] m_stable, nxt;
  logic [3:0]  m_press;
  logic        acc;

  always @(posedge clock) begin
    if (!resetn) begin
      for (int k = 0; k <= DEB; k++) hist[k] = RST;
      m_stable = RST;
      m_press  = 4'h0;
    end else begin
      nxt = m_stable;
      for (int c = 0; c < 14; c++) begin
        acc = 1'b1;
        for (int k = 1; k <= DEB; k++)
          if (hist[k][c] == m_stable[c]) acc = 1'b0;
        if (acc) nxt[c] = hist[1][c];
      end
      for (int b = 0; b < 4; b++) begin
        if (m_stable[b] && !nxt[b]) m_press[b] = 1'b1;
        else if (tb_if.key_clr[b]) m_press[b] = 1'b0;
      end
      m_stable = nxt;
      for (int k = DEB; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {tb_if.SW, tb_if.KEY};
    end
    #1;
    chk("model", {13'h0, tb_if.key_level, tb_if.sw_level, tb_if.key_press, tb_if.key_any},
                 {13'h0, ~m_stable[3:0], m_stable[13:4], m_press, |m_press});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    resetn        = 1'b0;
    tb_if.KEY     = 4'hF;
    tb_if.SW      = 10'h3FF;
    tb_if.key_clr = 4'h0;

    tick(3);
    chk("rst_key_level", {28'h0, tb_if.key_level}, 32'h0);
    chk("rst_sw_level",  {22'h0, tb_if.sw_level}, 32'h0);
    chk("rst_key_press", {28'h0, tb_if.key_press}, 32'h0);
    chk("rst_key_any",   {31'h0, tb_if.key_any}, 32'h0);
    resetn = 1'b1;
    tick(5);
    chk("sw_edge5", {22'h0, tb_if.sw_level}, 32'h0);
    tick(1);
    chk("sw_edge6", {22'h0, tb_if.sw_level}, 32'h3FF);
    chk("key_level_idle", {28'h0, tb_if.key_level}, 32'h0);

    // Clean press of key 2
    tb_if.KEY = 4'b1011;
    tick(5);
    chk("press_edge5", {28'h0, tb_if.key_press}, 32'h0);
    tick(1);
    chk("press_level", {28'h0, tb_if.key_level}, 32'h4);
    chk("press_flag",  {28'h0, tb_if.key_press}, 32'h4);
    chk("press_any",   {31'h0, tb_if.key_any}, 32'h1);
    tb_if.KEY = 4'hF;
    tick(6);
    chk("release_level", {28'h0, tb_if.key_level}, 32'h0);
    chk("release_flag",  {28'h0, tb_if.key_press}, 32'h4);

    // Bounce on key 0: pulses of 1, 2, 3 cycles, then hold low
    for (int w = 1; w <= 3; w++) begin
      tb_if.KEY = 4'b1110; tick(w);
      tb_if.KEY = 4'b1111; tick(w);
    end
    chk("bounce_quiet", {28'h0, tb_if.key_press}, 32'h4);
    tb_if.KEY = 4'b1110;
    tick(5);
    chk("bounce_edge5", {28'h0, tb_if.key_press}, 32'h4);
    tick(1);
    chk("bounce_edge6", {28'h0, tb_if.key_press}, 32'h5);

    // W1C on key 0
    tb_if.key_clr = 4'b0001; tick(1); tb_if.key_clr = 4'h0;
    chk("clear_flag", {28'h0, tb_if.key_press}, 32'h4);
    chk("clear_any",  {31'h0, tb_if.key_any}, 32'h1);

    // Clear arriving on the same edge that sets key 1
    tb_if.KEY = 4'b1100;
    tick(5);
    tb_if.key_clr = 4'b0010; tick(1); tb_if.key_clr = 4'h0;
    chk("collide_flag",  {28'h0, tb_if.key_press}, 32'h6);
    chk("collide_level", {28'h0, tb_if.key_level}, 32'h3);
    tb_if.key_clr = 4'b0100; tick(1); tb_if.key_clr = 4'h0;
    chk("clear_key2", {28'h0, tb_if.key_press}, 32'h2);

    // 3-cycle glitch on SW[9]
    tb_if.SW = 10'h1FF; tick(3);
    tb_if.SW = 10'h3FF; tick(8);
    chk("sw_glitch", {22'h0, tb_if.sw_level}, 32'h3FF);

    // Reset in the middle of SW[5] count
    tb_if.SW = 10'h3DF; tick(6);
    chk("sw5_low", {22'h0, tb_if.sw_level}, 32'h3DF);
    tb_if.SW = 10'h3FF; tick(3);
    resetn = 1'b0; tick(1);
    chk("midrst_sw",    {22'h0, tb_if.sw_level}, 32'h0);
    chk("midrst_press", {28'h0, tb_if.key_press}, 32'h0);
    resetn = 1'b1;
    tick(5);
    chk("midrst_edge5", {22'h0, tb_if.sw_level}, 32'h0);
    tick(1);
    chk("midrst_edge6", {22'h0, tb_if.sw_level}, 32'h3FF);
    chk("midrst_keys",  {28'h0, tb_if.key_press}, 32'h3);
    tick(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sc_input_cond.md
# sc_input_cond

Input conditioner for the board's push-buttons and slide switches. It sits between the raw `KEY`/`SW` pins and the `sc_hub` I/O decoder, so the hub only ever sees synchronized, debounced levels. It also provides sticky per-key press flags that the CPU clears with write-1-to-clear pulses through the hub. One instance per computer, clocked by the CPU `clock`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive cycles an input must hold a new value before it is accepted (1 ms at 50 MHz). Legal range 2 to 2^CNT_W − 1.
- `CNT_W`, default 16: debounce counter width.

Ports:
- `clock`  in  1: single clock. All state updates on the rising edge.
- `resetn`  in  1: reset, synchronous and active-low.
- `KEY`  in  4: raw push-buttons, asynchronous, active-low (0 = pressed).
- `SW`  in  10: raw slide switches, asynchronous, 1 = up.
- `key_clr`  in  4: write-1-to-clear strobe for `key_press`, one cycle wide, from the hub.
- `key_level`  out  4: debounced key state, active-high (1 = held).
- `sw_level`  out  10: debounced switch state.
- `key_press`  out  4: sticky flags, one per key, set on each debounced press.
- `key_any`  out  1: OR of `key_press`.

## Operation
- 14 identical channels: 4 keys and 10 switches. Each channel contains:
  - a 2-flop synchronizer `s1`→`s2`;
  - a `stable` register;
  - a `CNT_W`-bit counter `cnt`.
- Debounce, evaluated every edge:
  - `s2 == stable`: `cnt <= 0`.
  - `s2 != stable` and `cnt < DEBOUNCE_CYCLES−1`: `cnt <= cnt+1`.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES−1`: `stable <= s2`, `cnt <= 0`.
  - Any single-cycle return of `s2` to `stable` restarts the count from 0. Glitches shorter than `DEBOUNCE_CYCLES` never reach `stable`.
- Outputs:
  - `key_level[i] = ~stable_key[i]`.
  - `sw_level[j] = stable_sw[j]`.
  - Both are driven directly from registers, with no combinational path from the pins.
- Press flag, per key:
  - Set condition: the edge on which `stable_key[i]` transitions 1→0.
  - Clear condition: `key_clr[i]==1`.
  - If set and clear occur on the same edge, set wins, so no press is lost.
  - Otherwise the flag holds.
- Release (`stable` 0→1) never changes `key_press`.
- `key_clr` bits for keys whose flag is already 0 have no effect.
- `key_any` is combinational OR of the `key_press` registers.

## Timing
- Reset: on any edge with `resetn==0`, every register takes its reset value, overriding all other updates on that edge.
  - Key channels: `s1`, `s2`, `stable` = 1 (released).
  - Switch channels: `s1`, `s2`, `stable` = 0.
  - All `cnt` = 0 and `key_press` = 0.
  - Resulting outputs: `key_level`=4'h0, `sw_level`=10'h000, `key_press`=4'h0, `key_any`=0.
- Reset mid-count discards the partial count. After reset releases, a switch held up reaches `sw_level` after the full latency below.
- Latency, with edge 1 being the first edge to sample a new pin value held steady:
  - `s2` shows the value after edge 2.
  - `stable`, the level output and (for a press) `key_press` all update at edge `DEBOUNCE_CYCLES+2`.
- A pin change shorter than `DEBOUNCE_CYCLES` cycles at `s2` produces no output change.
- Counter wrap is impossible: `cnt` never exceeds `DEBOUNCE_CYCLES−1`.
- Channels are fully independent. Simultaneous changes on several pins each complete on their own schedule.

## Test plan
Bench uses `DEBOUNCE_CYCLES=4`, so latency is 6 edges.
- Reset: hold `resetn=0` for 3 edges with `KEY=4'hF`, `SW=10'h3FF`, then release. Outputs must read 0 during reset; `sw_level=10'h3FF` exactly 6 edges after release; `key_level=0` throughout.
- Clean press: drive `KEY[2]` 1→0 and hold. Required: `key_level=4'b0100`, `key_press=4'b0100` and `key_any=1` at edge 6. Release `KEY[2]`: `key_level` returns to 0 after 6 edges; `key_press` stays 4'b0100.
- Bounce: toggle `KEY[0]` with pulse widths 1, 2, 3 cycles, then hold low. Required: no output change during the bounce; `key_press[0]` sets exactly 6 edges after the final transition.
- Clear: with `key_press=4'b0101`, pulse `key_clr=4'b0001`. Required: `key_press=4'b0100` after that edge.
- Set/clear collision: assert `key_clr[1]` on the exact edge where `key_press[1]` would set. Required: `key_press[1]=1`.
- Switch glitch and reset mid-count:
  - A 3-cycle pulse on `SW[9]` must leave `sw_level` unchanged.
  - Holding `SW[5]=1` and asserting `resetn=0` on edge 4 of its count must give `sw_level[5]=0` at reset, then `1` exactly 6 edges after release.
